// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle CPU control unit.
// Opcode classes always come from the top 4 bits of the latched opcode.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        HALT,
        FAULT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LI    = 4'b1000;
    localparam logic [3:0] OP_MOV   = 4'b1001;
    localparam logic [3:0] OP_LOAD  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_BZ    = 4'b1101;
    localparam logic [3:0] OP_CALL  = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_RA  = 2'b01;
    localparam logic [1:0] PCSRC_ALU = 2'b10;
    localparam logic [1:0] PCSRC_REG = 2'b11;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MOVE = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;

    // Control bundle minus the width-parameterised ALU operation field.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_load;
        logic       pc_enable;
        logic       ra_enable;
        logic       reg_write;
        logic       reg_imm;
        logic [1:0] pc_src;
        logic [1:0] wb_src;
        logic       busy;
        logic       halted;
        logic       mem_timeout;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [3:0] op_cls);
        return (op_cls == OP_LOAD) || (op_cls == OP_STORE);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit interface: IR/flag/memory-handshake inputs and datapath controls.
// slave = control unit side, master = datapath / memory side.
interface multicycle_control_unit_if #(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 3
);
    logic [OP_W-1:0]    opCode;
    logic               zero_flag;
    logic               mem_ready;
    logic               Mem_Read;
    logic               MemWrite_Enable;
    logic               IR_Load;
    logic               PC_Enable;
    logic               RA_Enable;
    logic               RegWrite_Enable;
    logic               Reg_Imm;
    logic [1:0]         PC_RA_ALU_REG;
    logic [1:0]         Alu_Move_Mem;
    logic [ALUOP_W-1:0] ALUOP;
    logic               busy;
    logic               halted;
    logic               mem_timeout;

    modport slave (
        input  opCode, zero_flag, mem_ready,
        output Mem_Read, MemWrite_Enable, IR_Load, PC_Enable, RA_Enable,
               RegWrite_Enable, Reg_Imm, PC_RA_ALU_REG, Alu_Move_Mem, ALUOP,
               busy, halted, mem_timeout
    );

    modport master (
        output opCode, zero_flag, mem_ready,
        input  Mem_Read, MemWrite_Enable, IR_Load, PC_Enable, RA_Enable,
               RegWrite_Enable, Reg_Imm, PC_RA_ALU_REG, Alu_Move_Mem, ALUOP,
               busy, halted, mem_timeout
    );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Purpose: combinational control decode from (state, latched opcode, zero flag, mem_ready).
// Latency: zero cycles, purely combinational.
// Backpressure: mem_ready only qualifies the completion pulses (IR_Load, MEM write-back, PC update).
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W       = 4,
    parameter int ALUOP_W    = 3,
    parameter bit BZ_ON_ZERO = 1'b1
) (
    input  state_t             state,
    input  logic [OP_W-1:0]    op_q,
    input  logic               zero_flag,
    input  logic               mem_ready,
    output ctrl_t              ctrl,
    output logic [ALUOP_W-1:0] aluop
);

    logic [3:0] op_cls;
    logic       bz_taken;

    assign op_cls   = op_q[OP_W-1 -: 4];
    assign bz_taken = BZ_ON_ZERO ? zero_flag : !zero_flag;

    always_comb begin
        ctrl  = '0;
        aluop = '0;
        unique case (state)
            FETCH: begin
                ctrl.busy     = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.ir_load  = mem_ready;
            end
            DECODE: begin
                ctrl.busy = 1'b1;
            end
            EXEC: begin
                ctrl.busy      = 1'b1;
                ctrl.pc_enable = 1'b1;
                ctrl.pc_src    = PCSRC_PC4;
                case (op_cls)
                    OP_NOP: ;
                    OP_LI: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_imm   = 1'b1;
                        ctrl.wb_src    = WB_IMM;
                    end
                    OP_MOV: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.wb_src    = WB_MOVE;
                    end
                    OP_LOAD, OP_STORE: begin
                        // PC advances only once the memory access completes
                        ctrl.pc_enable = 1'b0;
                        aluop          = ALUOP_W'(ALU_ADD);
                    end
                    OP_JMP: ctrl.pc_src = PCSRC_REG;
                    OP_BZ: begin
                        aluop       = ALUOP_W'(ALU_ADD);
                        ctrl.pc_src = bz_taken ? PCSRC_ALU : PCSRC_PC4;
                    end
                    OP_CALL: begin
                        ctrl.ra_enable = 1'b1;
                        ctrl.pc_src    = PCSRC_REG;
                    end
                    OP_HALT: ;
                    default: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.wb_src    = WB_ALU;
                        aluop          = op_q[ALUOP_W-1:0];
                    end
                endcase
            end
            MEM: begin
                ctrl.busy      = 1'b1;
                ctrl.pc_enable = mem_ready;
                ctrl.pc_src    = PCSRC_PC4;
                if (op_cls == OP_LOAD) begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.reg_write = mem_ready;
                    ctrl.wb_src    = mem_ready ? WB_MEM : WB_ALU;
                end else begin
                    ctrl.mem_write = 1'b1;
                end
            end
            HALT:    ctrl.halted      = 1'b1;
            FAULT:   ctrl.mem_timeout = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/MEM sequencer with memory timeout and HALT/FAULT sinks.
// Latency: 3 cycles per instruction, 4 for LOAD/STORE, plus any mem_ready stall cycles.
// Backpressure: stalls in FETCH/MEM while mem_ready is low; FAULT after MEM_WAIT_MAX+1 idle cycles.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W         = 4,
    parameter int ALUOP_W      = 3,
    parameter int MEM_WAIT_MAX = 15,
    parameter bit BZ_ON_ZERO   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.slave  bus
);

    localparam int CNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t             state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [CNT_W-1:0]   wait_cnt, wait_d;
    ctrl_t              ctrl;
    logic [ALUOP_W-1:0] aluop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wait_cnt <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_cnt;
        unique case (state_q)
            FETCH, MEM: begin
                if (bus.mem_ready) begin
                    state_d = (state_q == FETCH) ? DECODE : FETCH;
                    wait_d  = '0;
                end else if (wait_cnt == CNT_W'(MEM_WAIT_MAX)) begin
                    state_d = FAULT;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            DECODE: begin
                op_d    = bus.opCode;
                state_d = (bus.opCode[OP_W-1 -: 4] == OP_HALT) ? HALT : EXEC;
            end
            EXEC: begin
                state_d = is_mem_op(op_q[OP_W-1 -: 4]) ? MEM : FETCH;
            end
            default: ;
        endcase
    end

    ctrl_decode #(
        .OP_W       (OP_W),
        .ALUOP_W    (ALUOP_W),
        .BZ_ON_ZERO (BZ_ON_ZERO)
    ) u_decode (
        .state     (state_q),
        .op_q      (op_q),
        .zero_flag (bus.zero_flag),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl),
        .aluop     (aluop)
    );

    assign bus.Mem_Read        = ctrl.mem_read;
    assign bus.MemWrite_Enable = ctrl.mem_write;
    assign bus.IR_Load         = ctrl.ir_load;
    assign bus.PC_Enable       = ctrl.pc_enable;
    assign bus.RA_Enable       = ctrl.ra_enable;
    assign bus.RegWrite_Enable = ctrl.reg_write;
    assign bus.Reg_Imm         = ctrl.reg_imm;
    assign bus.PC_RA_ALU_REG   = ctrl.pc_src;
    assign bus.Alu_Move_Mem    = ctrl.wb_src;
    assign bus.ALUOP           = aluop;
    assign bus.busy            = ctrl.busy;
    assign bus.halted          = ctrl.halted;
    assign bus.mem_timeout     = ctrl.mem_timeout;

endmodule
